run_length_detector: RTL and testbench
======================================

Name: run_length_detector

Overview:
Parametrised successor to the lab's fixed "four consecutive equal bits" detector FSM. Samples a serial bit W on strobed cycles and tracks the length of the current run of identical bits. Flags when the run reaches RUN_LEN, with polarity selectable by Mode. Exports run status and a saturating match count for the LCD/LED display path.

Parameters:
RUN_LEN, 4, number of consecutive identical sampled bits that constitutes a match; legal range >= 2.
CNT_W, 8, width of the match event counter.
RL_W, $clog2(RUN_LEN+1), localparam; width of the run-length counter.

Ports:
Clk  input  1  clock; all state updates on posedge.
Rst  input  1  reset, asynchronous, active-low.
En  input  1  sample strobe; W is consumed only on cycles with En=1.
W  input  1  serial data bit.
Clr  input  1  synchronous clear of run state and match count; priority over En.
Mode  input  2  00 both polarities, 01 ones only, 10 zeros only, 11 detection off.
Z  output  1  level: current run has length RUN_LEN and its polarity is enabled by Mode.
Z_Pulse  output  1  one-cycle strobe when a run first reaches RUN_LEN with an enabled polarity.
Run_Len  output  RL_W  current run length, saturating at RUN_LEN; 0 in IDLE.
Run_Bit  output  1  polarity of the current run; 0 in IDLE.
Match_Cnt  output  CNT_W  number of Z_Pulse events, saturating at all-ones.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE, Run_Len=0, Run_Bit=0, Z_Pulse=0, Match_Cnt=0, Z=0.
- States: IDLE (no bit sampled since reset/Clr) and RUN.
- Clr=1 at a posedge: IDLE, Run_Len=0, Run_Bit=0, Match_Cnt=0, Z_Pulse=0. Overrides En in the same cycle.
- En=0 and Clr=0: all registers hold, Z_Pulse=0. Gaps in En do not break a run.
- En=1 in IDLE: Run_Bit<=W, Run_Len<=1, go to RUN.
- En=1 in RUN, W==Run_Bit: Run_Len<=min(Run_Len+1, RUN_LEN).
- En=1 in RUN, W!=Run_Bit: Run_Bit<=W, Run_Len<=1.
- Z is combinational from the registered Run_Len/Run_Bit and the live Mode: Z = RUN & (Run_Len==RUN_LEN) & enabled(Run_Bit, Mode).
  - Latency: Z rises in the cycle after the edge that samples the RUN_LEN-th bit.
  - Z stays high while the run continues and falls after the edge that samples an opposite bit.
  - A Mode change mid-run affects Z immediately.
- Z_Pulse is registered. It is 1 for exactly one cycle after the edge where Run_Len goes from RUN_LEN-1 to RUN_LEN and enabled(W, Mode) holds at that edge; otherwise 0.
  - Extending a saturated run does not re-pulse.
  - Enabling a polarity via Mode while already saturated does not pulse.
- Match_Cnt increments on the same edge that sets Z_Pulse and saturates at 2^CNT_W-1 (no wrap).
- Mode=11: Z=0, no pulses, no counting; run tracking continues.

Decomposition:
- Shared package: state enum {IDLE, RUN}; Mode constants MODE_BOTH=2'b00, MODE_ONES=2'b01, MODE_ZEROS=2'b10, MODE_OFF=2'b11; enabled(bit, mode) function.
- One sub-module, sat_counter (params WIDTH, MAX; ports Clk, Rst, Clr, Inc, Load1, Q). It holds at MAX and is instantiated twice:
  - run length: MAX=RUN_LEN, with Load1 for run restart;
  - match count: MAX=all-ones.

Test Plan:
- RUN_LEN=4, Mode=00, En=1, W=1,1,1,1,1,0: Z=1 after the 4th edge, still 1 after the 5th, 0 after the 6th. Z_Pulse one cycle after the 4th edge. Match_Cnt=1, Run_Len=1, Run_Bit=0 at end.
- Mode=01, W=0,0,0,0,0: Z=0, Z_Pulse=0, Match_Cnt unchanged, Run_Len=4. Then switch Mode to 00: Z=1 the same cycle, no pulse.
- W=1,1 (En=1), then 3 cycles En=0 with W=0, then W=1,1 (En=1): match detected, Z_Pulse once, Match_Cnt+1.
- CNT_W=2, Mode=00, five runs alternating 4x1 and 4x0: Match_Cnt reads 1,2,3,3,3.
- After 3 ones, drop Rst asynchronously mid-cycle: all outputs 0 before the next edge. After release, 3 ones give Z=0 and a 4th one gives Z=1.
- With Run_Len=3, assert Clr and En with W matching in the same cycle: IDLE, Run_Len=0, Match_Cnt=0, no Z_Pulse.

Source files
------------

// File: rtl/run_length_detector_pkg.sv
// Shared types, Mode encodings and the polarity-enable helper for the run-length detector.
package run_length_detector_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [1:0] MODE_BOTH  = 2'b00;
   localparam logic [1:0] MODE_ONES  = 2'b01;
   localparam logic [1:0] MODE_ZEROS = 2'b10;
   localparam logic [1:0] MODE_OFF   = 2'b11;

   // True when a run of polarity b may raise Z / count under the given mode.
   function automatic logic enabled(input logic b, input logic [1:0] mode);
      case (mode)
         MODE_BOTH:  return 1'b1;
         MODE_ONES:  return b;
         MODE_ZEROS: return ~b;
         default:    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Up-counter that holds at MAX; Load1 restarts the count at one, Clr zeroes it.
module sat_counter
   import run_length_detector_pkg::*;
#(
   parameter int unsigned      WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Clr,
   input  logic             Inc,
   input  logic             Load1,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         Q <= '0;
      end else if (Clr) begin
         Q <= '0;
      end else if (Load1) begin
         Q <= WIDTH'(1);
      end else if (Inc && (Q != MAX)) begin
         Q <= Q + WIDTH'(1);
      end
   end

endmodule

// File: rtl/run_length_detector.sv
// Tracks runs of identical strobed bits; flags runs of RUN_LEN with Mode-selected polarity.
module run_length_detector
   import run_length_detector_pkg::*;
#(
   parameter  int unsigned RUN_LEN = 4,
   parameter  int unsigned CNT_W   = 8,
   localparam int unsigned RL_W    = $clog2(RUN_LEN + 1)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             En,
   input  logic             W,
   input  logic             Clr,
   input  logic [1:0]       Mode,
   output logic             Z,
   output logic             Z_Pulse,
   output logic [RL_W-1:0]  Run_Len,
   output logic             Run_Bit,
   output logic [CNT_W-1:0] Match_Cnt
);

   state_t state_q, state_d;
   logic   bit_d;
   logic   pulse_d;
   logic   run_inc;
   logic   run_load1;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= IDLE;
         Run_Bit <= 1'b0;
         Z_Pulse <= 1'b0;
      end else begin
         state_q <= state_d;
         Run_Bit <= bit_d;
         Z_Pulse <= pulse_d;
      end
   end

   // Pulse only on the transition into saturation, never while extending it.
   always_comb begin
      state_d   = state_q;
      bit_d     = Run_Bit;
      pulse_d   = 1'b0;
      run_inc   = 1'b0;
      run_load1 = 1'b0;
      if (Clr) begin
         state_d = IDLE;
         bit_d   = 1'b0;
      end else if (En) begin
         case (state_q)
            IDLE: begin
               state_d   = RUN;
               bit_d     = W;
               run_load1 = 1'b1;
            end
            RUN: begin
               if (W == Run_Bit) begin
                  run_inc = 1'b1;
                  pulse_d = (Run_Len == RL_W'(RUN_LEN - 1)) && enabled(W, Mode);
               end else begin
                  bit_d     = W;
                  run_load1 = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign Z = (state_q == RUN) && (Run_Len == RL_W'(RUN_LEN)) && enabled(Run_Bit, Mode);

   sat_counter #(
      .WIDTH (RL_W),
      .MAX   (RL_W'(RUN_LEN))
   ) u_run_len (
      .Clk   (Clk),
      .Rst   (Rst),
      .Clr   (Clr),
      .Inc   (run_inc),
      .Load1 (run_load1),
      .Q     (Run_Len)
   );

   sat_counter #(
      .WIDTH (CNT_W),
      .MAX   ({CNT_W{1'b1}})
   ) u_match_cnt (
      .Clk   (Clk),
      .Rst   (Rst),
      .Clr   (Clr),
      .Inc   (pulse_d),
      .Load1 (1'b0),
      .Q     (Match_Cnt)
   );

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: vector table, corner sequences and random checks vs a history model.
module tb_run_length_detector;

   localparam int unsigned RUN_LEN = 4;
   localparam int unsigned RL_W    = $clog2(RUN_LEN + 1);
   localparam int          MAX8    = 255;
   localparam int          MAX2    = 3;

   logic       Clk;
   logic       Rst;
   logic       En;
   logic       W;
   logic       Clr;
   logic [1:0] Mode;

   logic            z, zp, rb;
   logic [RL_W-1:0] rl;
   logic [7:0]      cnt;
   logic            z2, zp2, rb2;
   logic [RL_W-1:0] rl2;
   logic [1:0]      cnt2;

   int n_cmp;
   int n_fail;

   run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
      .Clk(Clk), .Rst(Rst), .En(En), .W(W), .Clr(Clr), .Mode(Mode),
      .Z(z), .Z_Pulse(zp), .Run_Len(rl), .Run_Bit(rb), .Match_Cnt(cnt)
   );

   run_length_detector #(.RUN_LEN(RUN_LEN), .CNT_W(2)) dut2 (
      .Clk(Clk), .Rst(Rst), .En(En), .W(W), .Clr(Clr), .Mode(Mode),
      .Z(z2), .Z_Pulse(zp2), .Run_Len(rl2), .Run_Bit(rb2), .Match_Cnt(cnt2)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference model: recent sampled-bit history plus pulse and saturating counts.
   bit hist[$];
   int m_cnt;
   int m_cnt2;
   bit m_pulse;

   function automatic bit pol_ok(input bit b, input logic [1:0] m);
      return (m == 2'd0) || (m == 2'd1 && b) || (m == 2'd2 && !b);
   endfunction

   function automatic int trail();
      int n = 0;
      if (hist.size() == 0) return 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] == hist[hist.size() - 1]) n++;
         else break;
      end
      return n;
   endfunction

   function automatic void model_reset();
      hist.delete();
      m_cnt   = 0;
      m_cnt2  = 0;
      m_pulse = 0;
   endfunction

   function automatic void model_edge(input bit en, input bit w, input bit clr, input logic [1:0] m);
      m_pulse = 0;
      if (clr) begin
         model_reset();
      end else if (en) begin
         hist.push_back(w);
         if (hist.size() > RUN_LEN + 2) void'(hist.pop_front());
         if (trail() == RUN_LEN && pol_ok(w, m)) begin
            m_pulse = 1;
            if (m_cnt < MAX8) m_cnt++;
            if (m_cnt2 < MAX2) m_cnt2++;
         end
      end
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int  t;
      int  e_rl;
      bit  e_rb;
      bit  e_z;
      t    = trail();
      e_rl = (t > RUN_LEN) ? RUN_LEN : t;
      e_rb = (hist.size() == 0) ? 1'b0 : hist[hist.size() - 1];
      e_z  = (e_rl == RUN_LEN) && pol_ok(e_rb, Mode);
      chk("model_z",       32'(z),    32'(e_z));
      chk("model_z_pulse", 32'(zp),   32'(m_pulse));
      chk("model_run_len", 32'(rl),   e_rl);
      chk("model_run_bit", 32'(rb),   32'(e_rb));
      chk("model_cnt",     32'(cnt),  m_cnt);
      chk("model_z2",      32'(z2),   32'(e_z));
      chk("model_pulse2",  32'(zp2),  32'(m_pulse));
      chk("model_rl2",     32'(rl2),  e_rl);
      chk("model_rb2",     32'(rb2),  32'(e_rb));
      chk("model_cnt2",    32'(cnt2), m_cnt2);
   endtask

   task automatic step(input bit en, input bit w, input bit clr, input logic [1:0] m);
      En   = en;
      W    = w;
      Clr  = clr;
      Mode = m;
      @(posedge Clk);
      model_edge(en, w, clr, m);
      #1;
      check_model();
   endtask

   typedef struct {
      bit         en;
      bit         w;
      bit         clr;
      logic [1:0] mode;
      bit         z;
      bit         zp;
      int         rl;
      bit         rb;
      int         cnt;
   } vec_t;

   vec_t vt[14];

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      model_reset();
      Rst = 1'b0; En = 1'b0; W = 1'b0; Clr = 1'b0; Mode = 2'b00;

      // Vectors from reset: 1,1,1,1,1,0 then zeros under ones-only, then Mode changes.
      vt[0]  = '{1, 1, 0, 2'b00, 0, 0, 1, 1, 0};
      vt[1]  = '{1, 1, 0, 2'b00, 0, 0, 2, 1, 0};
      vt[2]  = '{1, 1, 0, 2'b00, 0, 0, 3, 1, 0};
      vt[3]  = '{1, 1, 0, 2'b00, 1, 1, 4, 1, 1};
      vt[4]  = '{1, 1, 0, 2'b00, 1, 0, 4, 1, 1};
      vt[5]  = '{1, 0, 0, 2'b00, 0, 0, 1, 0, 1};
      vt[6]  = '{1, 0, 0, 2'b01, 0, 0, 2, 0, 1};
      vt[7]  = '{1, 0, 0, 2'b01, 0, 0, 3, 0, 1};
      vt[8]  = '{1, 0, 0, 2'b01, 0, 0, 4, 0, 1};
      vt[9]  = '{1, 0, 0, 2'b01, 0, 0, 4, 0, 1};
      vt[10] = '{0, 1, 0, 2'b00, 1, 0, 4, 0, 1};
      vt[11] = '{0, 1, 0, 2'b10, 1, 0, 4, 0, 1};
      vt[12] = '{1, 0, 0, 2'b00, 1, 0, 4, 0, 1};
      vt[13] = '{0, 0, 0, 2'b11, 0, 0, 4, 0, 1};

      #12;
      chk("reset_z",       32'(z),   0);
      chk("reset_z_pulse", 32'(zp),  0);
      chk("reset_run_len", 32'(rl),  0);
      chk("reset_run_bit", 32'(rb),  0);
      chk("reset_cnt",     32'(cnt), 0);
      @(negedge Clk);
      Rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         step(vt[i].en, vt[i].w, vt[i].clr, vt[i].mode);
         chk($sformatf("vec%0d_z", i),       32'(z),   32'(vt[i].z));
         chk($sformatf("vec%0d_z_pulse", i), 32'(zp),  32'(vt[i].zp));
         chk($sformatf("vec%0d_run_len", i), 32'(rl),  vt[i].rl);
         chk($sformatf("vec%0d_run_bit", i), 32'(rb),  32'(vt[i].rb));
         chk($sformatf("vec%0d_cnt", i),     32'(cnt), vt[i].cnt);
      end

      // En gaps do not break a run.
      step(0, 0, 1, 2'b00);
      step(1, 1, 0, 2'b00);
      step(1, 1, 0, 2'b00);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00);
      step(1, 1, 0, 2'b00);
      chk("gap_no_early_z", 32'(z), 0);
      step(1, 1, 0, 2'b00);
      chk("gap_pulse", 32'(zp),  1);
      chk("gap_cnt",   32'(cnt), 1);
      step(0, 1, 0, 2'b00);
      chk("gap_pulse_once", 32'(zp), 0);

      // Two-bit counter saturates at 3.
      step(0, 0, 1, 2'b00);
      for (int r = 0; r < 5; r++) begin
         for (int k = 0; k < 4; k++) step(1, (r % 2) == 0, 0, 2'b00);
         chk($sformatf("sat_run%0d_cnt2", r), 32'(cnt2), (r < 3) ? r + 1 : 3);
      end

      // Asynchronous reset mid-cycle, then a fresh run.
      step(0, 0, 1, 2'b00);
      for (int k = 0; k < 3; k++) step(1, 1, 0, 2'b00);
      #3;
      Rst = 1'b0;
      model_reset();
      #1;
      chk("arst_z",       32'(z),   0);
      chk("arst_run_len", 32'(rl),  0);
      chk("arst_run_bit", 32'(rb),  0);
      chk("arst_cnt",     32'(cnt), 0);
      @(negedge Clk);
      Rst = 1'b1;
      for (int k = 0; k < 3; k++) step(1, 1, 0, 2'b00);
      chk("arst_3ones_z", 32'(z), 0);
      step(1, 1, 0, 2'b00);
      chk("arst_4ones_z", 32'(z), 1);

      // Clr beats En at the edge that would have completed the run.
      step(0, 0, 1, 2'b00);
      for (int k = 0; k < 3; k++) step(1, 1, 0, 2'b00);
      chk("clr_pre_run_len", 32'(rl), 3);
      step(1, 1, 1, 2'b00);
      chk("clr_run_len", 32'(rl),  0);
      chk("clr_cnt",     32'(cnt), 0);
      chk("clr_pulse",   32'(zp),  0);
      chk("clr_z",       32'(z),   0);

      // Random stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(99) < 75, 1'($urandom_range(1)),
              $urandom_range(199) == 0, 2'($urandom_range(3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
